// File: rtl/eth_axis_mac_swap_loopback.sv
// eth_axis_mac_swap_loopback
// AXI-stream loopback for the logic_clk side of the 1G MAC/FIFO wrapper.
// Captures the 12-byte address header of each received frame, re-emits it
// with destination and source MAC swapped, then passes the rest of the frame
// straight through. Frames of 12 bytes or fewer are dropped and counted.
// Optional build macro ETH_LOOPBACK_FILTER_EN: frames whose DST is neither
// LOCAL_MAC nor broadcast are discarded. Broadcast frames are answered with
// LOCAL_MAC as the source address.
module eth_axis_mac_swap_loopback #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic                 logic_clk,
    input  logic                 logic_rst,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [CNT_WIDTH-1:0] looped_count,
    output logic [CNT_WIDTH-1:0] dropped_count
);

    localparam logic [3:0]           HDR_LAST = 4'd11;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_EMIT = 3'd2,
        ST_PASS = 3'd3
`ifdef ETH_LOOPBACK_FILTER_EN
        ,
        ST_DROP = 3'd4
`endif
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  act_r;        // low for the first cycle after reset so tready starts at 0
    logic [95:0]           hdr_r;        // header byte i lives in bits [8*i+7:8*i]
    logic [3:0]            idx_r;
    logic [3:0]            wr_idx_s;
    logic [3:0]            emit_idx_r;
    logic                  bcast_r;
    logic                  bcast_s;
    logic [7:0]            tdata_r;
    logic                  tvalid_r;
    logic [CNT_WIDTH-1:0]  looped_r;
    logic [CNT_WIDTH-1:0]  dropped_r;
    logic                  s_fire_s;
    logic                  hdr_wr_s;
    logic                  drop_inc_s;
    logic                  loop_inc_s;
    logic                  emit_start_s;
    logic                  emit_adv_s;

    // Header output byte k (0..11): captured SRC first, then captured DST,
    // or LOCAL_MAC in the source slot when answering a broadcast.
    function automatic logic [7:0] emit_byte(input logic [95:0] hdr,
                                             input logic [3:0]  k,
                                             input logic        bcast);
        logic [95:0] hsh;
        logic [47:0] msh;
        logic [7:0]  b;
        hsh = 96'd0;
        msh = 48'd0;
        if (k < 4'd6) begin
            hsh = hdr >> {k + 4'd6, 3'b000};
            b   = hsh[7:0];
        end else if (bcast) begin
            msh = LOCAL_MAC >> {4'd11 - k, 3'b000};
            b   = msh[7:0];
        end else begin
            hsh = hdr >> {k - 4'd6, 3'b000};
            b   = hsh[7:0];
        end
        return b;
    endfunction

`ifdef ETH_LOOPBACK_FILTER_EN
    logic [47:0] dst_s;
    logic        dst_local_s;
    logic        dst_bcast_s;

    // Assemble captured DST (byte 0 in the top bits) and compare with the accepted addresses
    always_comb begin
        dst_s       = {hdr_r[7:0], hdr_r[15:8], hdr_r[23:16],
                       hdr_r[31:24], hdr_r[39:32], hdr_r[47:40]};
        dst_local_s = (dst_s == LOCAL_MAC);
        dst_bcast_s = (dst_s == 48'hFFFF_FFFF_FFFF);
    end

    assign bcast_s = dst_bcast_s;
`else
    assign bcast_s = 1'b0;
`endif

    // State register
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic, receive-side ready and datapath strobes
    always_comb begin
        state_s       = state_r;
        s_axis_tready = 1'b0;
        hdr_wr_s      = 1'b0;
        drop_inc_s    = 1'b0;
        loop_inc_s    = 1'b0;
        emit_start_s  = 1'b0;
        emit_adv_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                s_axis_tready = act_r;
                if (s_axis_tvalid && act_r) begin
                    hdr_wr_s = 1'b1;
                    if (s_axis_tlast) begin
                        drop_inc_s = 1'b1;
                    end else begin
                        state_s = ST_HDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                s_axis_tready = act_r;
                if (s_axis_tvalid && act_r) begin
                    hdr_wr_s = 1'b1;
                    if (s_axis_tlast) begin
                        drop_inc_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else if (idx_r == HDR_LAST) begin
`ifdef ETH_LOOPBACK_FILTER_EN
                        if (dst_local_s || dst_bcast_s) begin
                            emit_start_s = 1'b1;
                            state_s      = ST_EMIT;
                        end else begin
                            state_s = ST_DROP;
                        end
`else
                        emit_start_s = 1'b1;
                        state_s      = ST_EMIT;
`endif
                    end else begin
                        state_s = ST_HDR;
                    end
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_EMIT: begin
                if (tvalid_r && m_axis_tready) begin
                    emit_adv_s = 1'b1;
                    if (emit_idx_r == HDR_LAST) begin
                        state_s = ST_PASS;
                    end else begin
                        state_s = ST_EMIT;
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_PASS: begin
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    loop_inc_s = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_PASS;
                end
            end
`ifdef ETH_LOOPBACK_FILTER_EN
            ST_DROP: begin
                s_axis_tready = act_r;
                if (s_axis_tvalid && act_r && s_axis_tlast) begin
                    drop_inc_s = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Header write slot: a new frame always starts at byte 0
    always_comb begin
        if (state_r == ST_IDLE) begin
            wr_idx_s = 4'd0;
        end else begin
            wr_idx_s = idx_r;
        end
    end

    assign s_fire_s = s_axis_tvalid & s_axis_tready;

    // Transmit steering: direct pass-through in PASS, registered header beats otherwise
    always_comb begin
        if (state_r == ST_PASS) begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tuser  = s_axis_tuser;
        end else begin
            m_axis_tdata  = tdata_r;
            m_axis_tvalid = tvalid_r;
            m_axis_tlast  = 1'b0;
            m_axis_tuser  = 1'b0;
        end
    end

    // Header capture, swapped-header sequencing and frame counters
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            act_r      <= 1'b0;
            hdr_r      <= 96'd0;
            idx_r      <= 4'd0;
            emit_idx_r <= 4'd0;
            bcast_r    <= 1'b0;
            tdata_r    <= 8'd0;
            tvalid_r   <= 1'b0;
            looped_r   <= CNT_ZERO;
            dropped_r  <= CNT_ZERO;
        end else begin
            act_r <= 1'b1;
            if (hdr_wr_s && s_fire_s) begin
                for (int i = 0; i < 12; i++) begin
                    if (wr_idx_s == 4'(i)) begin
                        hdr_r[8*i +: 8] <= s_axis_tdata;
                    end
                end
                idx_r <= wr_idx_s + 4'd1;
            end
            if (emit_start_s) begin
                tvalid_r   <= 1'b1;
                tdata_r    <= emit_byte(hdr_r, 4'd0, bcast_s);
                emit_idx_r <= 4'd0;
                bcast_r    <= bcast_s;
            end else if (emit_adv_s) begin
                if (emit_idx_r == HDR_LAST) begin
                    tvalid_r <= 1'b0;
                    tdata_r  <= 8'd0;
                end else begin
                    emit_idx_r <= emit_idx_r + 4'd1;
                    tdata_r    <= emit_byte(hdr_r, emit_idx_r + 4'd1, bcast_r);
                end
            end
            if (loop_inc_s) begin
                looped_r <= looped_r + CNT_ONE;
            end
            if (drop_inc_s) begin
                dropped_r <= dropped_r + CNT_ONE;
            end
        end
    end

    assign looped_count  = looped_r;
    assign dropped_count = dropped_r;

endmodule

// File: tb/tb_eth_axis_mac_swap_loopback.sv
// Self-checking bench for eth_axis_mac_swap_loopback: randomized frames are
// compared beat-for-beat against a frame-level reference model.
module tb_eth_axis_mac_swap_loopback;

    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC0 = 48'haa_bb_cc_dd_ee_ff;

    logic        logic_clk = 1'b0;
    logic        logic_rst = 1'b1;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] looped_count;
    logic [15:0] dropped_count;

    int          checks = 0;
    int          errors = 0;
    int          vprob = 100;
    int          rmode = 0;
    int          out_idx = 0;
    int          emit_viol = 0;
    logic [15:0] exp_looped = 16'd0;
    logic [15:0] exp_dropped = 16'd0;
    logic [7:0]  fr_q[$];
    logic [9:0]  mon_q[$];
    logic [9:0]  exp_q[$];

    always #5 logic_clk = ~logic_clk;

    eth_axis_mac_swap_loopback #(.CNT_WIDTH(16), .LOCAL_MAC(LMAC)) dut (
        .logic_clk     (logic_clk),
        .logic_rst     (logic_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .looped_count  (looped_count),
        .dropped_count (dropped_count)
    );

    // Record every transmit transfer; the first 12 beats of a frame must not see receive ready
    always @(negedge logic_clk) begin
        if (logic_rst) begin
            out_idx <= 0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                mon_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
                out_idx <= m_axis_tlast ? 0 : out_idx + 1;
            end
            if (m_axis_tvalid && out_idx < 12 && s_axis_tready) begin
                emit_viol <= emit_viol + 1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] mon_at(input int k);
        return (k >= 0 && k < mon_q.size()) ? mon_q[k] : 10'h3ff;
    endfunction

    function automatic logic [9:0] exp_at(input int k);
        return (k >= 0 && k < exp_q.size()) ? exp_q[k] : 10'h3ff;
    endfunction

    function automatic int first_diff();
        int n;
        n = (mon_q.size() > exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k >= mon_q.size() || k >= exp_q.size()) return k;
            if (mon_q[k] !== exp_q[k]) return k;
        end
        return -1;
    endfunction

    task automatic make_frame(input int len, input logic [47:0] dst, input logic [47:0] src);
        logic [95:0] h;
        h = {dst, src};
        fr_q.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 12) fr_q.push_back(h[95 - 8*i -: 8]);
            else        fr_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // Reference model: what the loopback should transmit for fr_q, and which counter moves
    task automatic build_expected(input bit bad);
        logic [47:0] dst;
        logic [47:0] lm;
        logic [47:0] sh;
        bit          bc;
        bit          keep;
        int          last;
        exp_q.delete();
        if (fr_q.size() <= 12) begin
            exp_dropped = exp_dropped + 16'd1;
            return;
        end
        dst  = {fr_q[0], fr_q[1], fr_q[2], fr_q[3], fr_q[4], fr_q[5]};
        lm   = LMAC;
        bc   = 1'b0;
        keep = 1'b1;
`ifdef ETH_LOOPBACK_FILTER_EN
        bc   = (dst == 48'hFFFF_FFFF_FFFF);
        keep = bc || (dst == lm);
`endif
        if (!keep) begin
            exp_dropped = exp_dropped + 16'd1;
            return;
        end
        for (int i = 0; i < 6; i++) exp_q.push_back({2'b00, fr_q[6 + i]});
        for (int i = 0; i < 6; i++) begin
            sh = lm >> (8 * (5 - i));
            exp_q.push_back({2'b00, bc ? sh[7:0] : fr_q[i]});
        end
        last = fr_q.size() - 1;
        for (int i = 12; i <= last; i++) exp_q.push_back({i == last, bad && (i == last), fr_q[i]});
        exp_looped = exp_looped + 16'd1;
    endtask

    // Drive the first n bytes of fr_q; called and returns at posedge+1
    task automatic send_frame(input int n, input bit with_last, input bit bad);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < n && guard < 4000) begin
            if (!s_axis_tvalid) s_axis_tvalid = ($urandom_range(0, 99) < vprob);
            s_axis_tdata = fr_q[i];
            s_axis_tlast = with_last && (i == n - 1);
            s_axis_tuser = bad && with_last && (i == n - 1);
            case (rmode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge logic_clk);
            if (s_axis_tvalid && s_axis_tready) begin
                i++;
                @(posedge logic_clk); #1;
                s_axis_tvalid = 1'b0;
            end else begin
                @(posedge logic_clk); #1;
            end
            guard++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL send_timeout accepted %0d of %0d bytes", i, n);
        end
    endtask

    task automatic run_frame(input bit bad);
        build_expected(bad);
        mon_q.delete();
        send_frame(fr_q.size(), 1'b1, bad);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, looped_count, dropped_count} !== 44'd0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b vld=%b last=%b user=%b data=%h cnt=%0d/%0d want all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, looped_count, dropped_count);
        end
        @(negedge logic_clk);
        logic_rst = 1'b0;
        @(posedge logic_clk); #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_basic;
        int d;
        vprob = 100;
        rmode = 0;
        make_frame(64, LMAC, SRC0);
        run_frame(1'b0);
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL basic_stream beat %0d got %h want %h (beats %0d want %0d)", d, mon_at(d), exp_at(d), mon_q.size(), exp_q.size());
        end
        checks++;
        if (looped_count !== 16'd1 || looped_count !== exp_looped) begin
            errors++;
            $display("FAIL basic_looped got %0d want %0d", looped_count, exp_looped);
        end
    endtask

    task automatic test_runt;
        int d;
        make_frame(10, LMAC, SRC0);
        run_frame(1'b0);
        checks++;
        if (mon_q.size() !== 0 || dropped_count !== exp_dropped) begin
            errors++;
            $display("FAIL runt_drop got beats=%0d dropped=%0d want beats=0 dropped=%0d", mon_q.size(), dropped_count, exp_dropped);
        end
        make_frame(64, LMAC, 48'h12_34_56_78_9a_bc);
        run_frame(1'b0);
        d = first_diff();
        checks++;
        if (d != -1 || looped_count !== exp_looped) begin
            errors++;
            $display("FAIL after_runt beat %0d got %h want %h looped %0d want %0d", d, mon_at(d), exp_at(d), looped_count, exp_looped);
        end
    endtask

    task automatic test_backpressure;
        int d;
        rmode = 1;
        emit_viol = 0;
        make_frame(64, LMAC, 48'h0a_0b_0c_0d_0e_0f);
        run_frame(1'b0);
        rmode = 0;
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL backpressure_stream beat %0d got %h want %h (beats %0d want %0d)", d, mon_at(d), exp_at(d), mon_q.size(), exp_q.size());
        end
        checks++;
        if (emit_viol !== 0) begin
            errors++;
            $display("FAIL emit_ready got %0d ready cycles during header emit want 0", emit_viol);
        end
    endtask

    task automatic test_tuser;
        int d;
        make_frame(60, LMAC, SRC0);
        run_frame(1'b1);
        d = first_diff();
        checks++;
        if (d != -1 || looped_count !== exp_looped) begin
            errors++;
            $display("FAIL bad_frame beat %0d got %h want %h looped %0d want %0d", d, mon_at(d), exp_at(d), looped_count, exp_looped);
        end
    endtask

    task automatic test_boundary;
        int d;
        int lens[3];
        lens = '{1, 12, 13};
        for (int j = 0; j < 3; j++) begin
            make_frame(lens[j], LMAC, 48'hde_ad_be_ef_00_11);
            run_frame(1'b0);
            d = first_diff();
            checks++;
            if (d != -1 || looped_count !== exp_looped || dropped_count !== exp_dropped) begin
                errors++;
                $display("FAIL boundary_len%0d beat %0d got %h want %h cnt %0d/%0d want %0d/%0d", lens[j], d, mon_at(d), exp_at(d),
                         looped_count, dropped_count, exp_looped, exp_dropped);
            end
        end
    endtask

    task automatic test_back_to_back;
        int d;
        vprob = 100;
        rmode = 0;
        for (int j = 0; j < 3; j++) begin
            make_frame(13 + j * 7, LMAC, {16'h5a5a, 32'($urandom)});
            run_frame(1'b0);
            d = first_diff();
            checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL back_to_back_%0d beat %0d got %h want %h", j, d, mon_at(d), exp_at(d));
            end
        end
    endtask

    task automatic test_random;
        int d;
        int len;
        logic [47:0] dst;
        vprob = 60;
        rmode = 2;
        for (int j = 0; j < 24; j++) begin
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 12)) : int'($urandom_range(13, 90));
            case ($urandom_range(0, 2))
                0:       dst = LMAC;
                1:       dst = 48'hFFFF_FFFF_FFFF;
                default: dst = {16'($urandom), 32'($urandom)};
            endcase
            make_frame(len, dst, {16'($urandom), 32'($urandom)});
            run_frame(1'($urandom_range(0, 1)));
            d = first_diff();
            checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL random_%0d len %0d beat %0d got %h want %h", j, len, d, mon_at(d), exp_at(d));
            end
        end
        vprob = 100;
        rmode = 0;
        checks++;
        if (looped_count !== exp_looped || dropped_count !== exp_dropped) begin
            errors++;
            $display("FAIL random_counts got %0d/%0d want %0d/%0d", looped_count, dropped_count, exp_looped, exp_dropped);
        end
    endtask

    task automatic test_reset_emit;
        int d;
        make_frame(64, LMAC, SRC0);
        mon_q.delete();
        send_frame(12, 1'b0, 1'b0);
        repeat (5) @(posedge logic_clk);
        #2;
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== fr_q[11]) begin
            errors++;
            $display("FAIL emit_beat5 got vld=%b data=%h want vld=1 data=%h", m_axis_tvalid, m_axis_tdata, fr_q[11]);
        end
        logic_rst = 1'b1;
        #1;
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, looped_count, dropped_count} !== 44'd0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b vld=%b data=%h cnt=%0d/%0d want all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, looped_count, dropped_count);
        end
        exp_looped  = 16'd0;
        exp_dropped = 16'd0;
        @(negedge logic_clk);
        logic_rst = 1'b0;
        @(posedge logic_clk); #1;
        make_frame(40, LMAC, 48'h66_55_44_33_22_11);
        run_frame(1'b0);
        d = first_diff();
        checks++;
        if (d != -1 || looped_count !== 16'd1) begin
            errors++;
            $display("FAIL after_reset beat %0d got %h want %h looped %0d want 1", d, mon_at(d), exp_at(d), looped_count);
        end
    endtask

`ifdef ETH_LOOPBACK_FILTER_EN
    task automatic test_filter;
        int d;
        logic [47:0] srcf;
        make_frame(64, 48'h11_22_33_44_55_66, SRC0);
        run_frame(1'b0);
        checks++;
        if (mon_q.size() !== 0 || dropped_count !== exp_dropped) begin
            errors++;
            $display("FAIL filter_drop got beats=%0d dropped=%0d want beats=0 dropped=%0d", mon_q.size(), dropped_count, exp_dropped);
        end
        make_frame(64, 48'hFFFF_FFFF_FFFF, SRC0);
        run_frame(1'b0);
        d = first_diff();
        srcf = {mon_at(6)[7:0], mon_at(7)[7:0], mon_at(8)[7:0], mon_at(9)[7:0], mon_at(10)[7:0], mon_at(11)[7:0]};
        checks++;
        if (d != -1 || srcf !== LMAC) begin
            errors++;
            $display("FAIL filter_bcast beat %0d got %h want %h src %h want %h", d, mon_at(d), exp_at(d), srcf, LMAC);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_runt();
        test_backpressure();
        test_tuser();
        test_boundary();
        test_back_to_back();
`ifdef ETH_LOOPBACK_FILTER_EN
        test_filter();
`endif
        test_random();
        test_reset_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
